// File: rtl/noc_mem_pkg.sv
// ----------------------------------------------------------------------------
// noc_mem_pkg
// Shared types and constants for the NOC memory responder:
//   - NOC geometry (RADIX, BIT_WIDTH, ADDR_WIDTH)
//   - address field positions (write flag, source core index)
//   - responder FSM state encoding
//   - queued request record {data, addr}
//   - src_onehot(): source index -> one-hot destination core
// ----------------------------------------------------------------------------
package noc_mem_pkg;

  localparam int RADIX      = 2;
  localparam int BIT_WIDTH  = 32;
  localparam int ADDR_WIDTH = 16;

  // Address layout, MSB down: write flag, source core index, ignored bits,
  // and the word index in the low bits (its width depends on MEM_DEPTH).
  localparam int SRC_W   = $clog2(RADIX);
  localparam int WR_BIT  = ADDR_WIDTH - 1;
  localparam int SRC_LSB = WR_BIT - SRC_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [BIT_WIDTH-1:0]  data;
    logic [ADDR_WIDTH-1:0] addr;
  } req_t;

  // A source index with no matching core yields an all-zero vector.
  function automatic logic [RADIX-1:0] src_onehot(input logic [SRC_W-1:0] src);
    // NOTE: assign a default before the loop so every bit has a value on
    // every path; the same habit keeps always_comb blocks latch-free.
    src_onehot = '0;
    for (int i = 0; i < RADIX; i++) begin
      src_onehot[i] = (src == SRC_W'(i));
    end
  endfunction

endpackage

// File: rtl/noc_req_fifo.sv
// ----------------------------------------------------------------------------
// noc_req_fifo
// Synchronous show-ahead FIFO with wrap-bit pointers.
//   clk, rst_l : clock, asynchronous active-low reset (clears pointers)
//   push, wdata: write request; accepted when not full, or when full and a
//                pop happens on the same edge
//   pop        : consume head entry (ignored when empty)
//   rdata      : current head entry (valid while !empty)
//   full, empty: occupancy flags
// ----------------------------------------------------------------------------
module noc_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty when the
  // index bits match.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] store [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = store[rd_ptr[PTR_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: queue storage is left unreset; an entry is only ever read after
  // it has been written, because empty gates every pop.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/noc_mem_responder.sv
// ----------------------------------------------------------------------------
// noc_mem_responder
// Memory endpoint on the NOC: queues core-to-memory requests, services them
// one at a time with a fixed access latency, and returns a single-cycle
// response to the requesting core.
//   clk, rst_l            : clock, asynchronous active-low reset
//   en_C2M_OUT            : request valid
//   Data_C2M_OUT          : write data (ignored for reads)
//   Addr_C2M_OUT          : {write flag, source core, ..., word index}
//   en_M2C_IN             : response valid (one cycle per request)
//   Data_M2C_IN           : read data, or echoed write data
//   AccessComplete_M2C_IN : one-hot destination core
//   ready_C2M             : request queue not full
//   overflow_err          : sticky, a request was dropped
// ----------------------------------------------------------------------------
module noc_mem_responder
  import noc_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 2,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  en_C2M_OUT,
  input  logic [BIT_WIDTH-1:0]  Data_C2M_OUT,
  input  logic [ADDR_WIDTH-1:0] Addr_C2M_OUT,
  output logic                  en_M2C_IN,
  output logic [BIT_WIDTH-1:0]  Data_M2C_IN,
  output logic [RADIX-1:0]      AccessComplete_M2C_IN,
  output logic                  ready_C2M,
  output logic                  overflow_err
);

  localparam int WORD_W = $clog2(MEM_DEPTH);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_WIDTH-1:0] rsp_data;
  logic [RADIX-1:0]     rsp_onehot;
  logic [BIT_WIDTH-1:0] mem [MEM_DEPTH];

  req_t              in_req;
  req_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              head_is_write;
  logic [SRC_W-1:0]  head_src;
  logic [WORD_W-1:0] head_word;
  logic              addr_unused;

  assign in_req = '{data: Data_C2M_OUT, addr: Addr_C2M_OUT};

  // The head is consumed only from IDLE; a request arriving while full is
  // still taken if that pop frees a slot on the same edge.
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign push      = en_C2M_OUT && (!fifo_full || pop);
  assign ready_C2M = !fifo_full;

  assign head_is_write = head.addr[WR_BIT];
  assign head_src      = head.addr[SRC_LSB +: SRC_W];
  assign head_word     = head.addr[WORD_W-1:0];
  // Middle address bits carry no meaning here; fold them so they are used.
  assign addr_unused   = ^head.addr;

  noc_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(req_t))
  ) u_req_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (push),
    .pop   (pop),
    .wdata (in_req),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Memory contents are observable through reads after reset, so every
  // word is cleared along with the control state.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (pop && head_is_write) begin
      mem[head_word] <= head.data;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      overflow_err <= 1'b0;
    end else if (en_C2M_OUT && fifo_full && !pop) begin
      overflow_err <= 1'b1;
    end
  end

  // Response outputs are registered and loaded only on entry to RESP, so
  // they read as zero in every other state.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state                 <= ST_IDLE;
      cnt                   <= '0;
      rsp_data              <= '0;
      rsp_onehot            <= '0;
      en_M2C_IN             <= 1'b0;
      Data_M2C_IN           <= '0;
      AccessComplete_M2C_IN <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            // Writes echo their data; reads capture the pre-write word,
            // which already reflects every earlier popped write.
            rsp_data   <= head_is_write ? head.data : mem[head_word];
            rsp_onehot <= src_onehot(head_src);
            cnt        <= CNT_W'(LATENCY - 1);
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state                 <= ST_RESP;
            en_M2C_IN             <= 1'b1;
            Data_M2C_IN           <= rsp_data;
            AccessComplete_M2C_IN <= rsp_onehot;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state                 <= ST_IDLE;
          en_M2C_IN             <= 1'b0;
          Data_M2C_IN           <= '0;
          AccessComplete_M2C_IN <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_noc_mem_responder
// Directed bench for noc_mem_responder (RADIX=2, 16-bit addr, 32-bit data,
// FIFO_DEPTH=4, LATENCY=2, MEM_DEPTH=16). A transaction-level model predicts
// acceptance, drop, response cycle and payload of every request; a compare
// process checks all outputs against it on every falling edge. Hand-computed
// literals pin the model on the key scenarios.
// ----------------------------------------------------------------------------
module tb_noc_mem_responder;
  import noc_mem_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int LATENCY    = 2;
  localparam int MEM_DEPTH  = 16;

  logic                  clk   = 1'b0;
  logic                  rst_l = 1'b0;
  logic                  en_C2M_OUT   = 1'b0;
  logic [BIT_WIDTH-1:0]  Data_C2M_OUT = '0;
  logic [ADDR_WIDTH-1:0] Addr_C2M_OUT = '0;
  logic                  en_M2C_IN;
  logic [BIT_WIDTH-1:0]  Data_M2C_IN;
  logic [RADIX-1:0]      AccessComplete_M2C_IN;
  logic                  ready_C2M;
  logic                  overflow_err;

  noc_mem_responder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LATENCY    (LATENCY),
    .MEM_DEPTH  (MEM_DEPTH)
  ) dut (
    .clk                   (clk),
    .rst_l                 (rst_l),
    .en_C2M_OUT            (en_C2M_OUT),
    .Data_C2M_OUT          (Data_C2M_OUT),
    .Addr_C2M_OUT          (Addr_C2M_OUT),
    .en_M2C_IN             (en_M2C_IN),
    .Data_M2C_IN           (Data_M2C_IN),
    .AccessComplete_M2C_IN (AccessComplete_M2C_IN),
    .ready_C2M             (ready_C2M),
    .overflow_err          (overflow_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;   // rising edges seen out of reset

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    int                   pop_e;
    int                   resp_e;
    logic [BIT_WIDTH-1:0] data;
    logic [RADIX-1:0]     oh;
  } exp_t;

  exp_t                 pend[$];
  logic [BIT_WIDTH-1:0] mdl_mem [MEM_DEPTH];
  int                   tail_resp = -100;
  bit                   mdl_ovf   = 1'b0;
  bit                   exp_en    = 1'b0;
  logic [BIT_WIDTH-1:0] exp_data  = '0;
  logic [RADIX-1:0]     exp_oh    = '0;
  bit                   exp_ready = 1'b1;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pend.delete();
      foreach (mdl_mem[i]) mdl_mem[i] = '0;
      tail_resp = -100;
      mdl_ovf   = 1'b0;
      exp_en    = 1'b0;
      exp_data  = '0;
      exp_oh    = '0;
      exp_ready = 1'b1;
    end else begin
      int   e;
      int   occ;
      bit   pop_now;
      exp_t n;
      cyc++;
      e       = cyc;
      occ     = 0;
      pop_now = 1'b0;
      foreach (pend[i]) begin
        if (pend[i].pop_e >= e) occ++;
        if (pend[i].pop_e == e) pop_now = 1'b1;
      end
      if (en_C2M_OUT) begin
        if (occ < FIFO_DEPTH || pop_now) begin
          // Service slot: one response every LATENCY+2 edges at most.
          n.pop_e  = (e + 1 > tail_resp + 2) ? e + 1 : tail_resp + 2;
          n.resp_e = n.pop_e + LATENCY;
          tail_resp = n.resp_e;
          n.oh = (Addr_C2M_OUT[14]) ? 2'b10 : 2'b01;
          if (Addr_C2M_OUT[15]) begin
            mdl_mem[Addr_C2M_OUT[3:0]] = Data_C2M_OUT;
            n.data = Data_C2M_OUT;
          end else begin
            n.data = mdl_mem[Addr_C2M_OUT[3:0]];
          end
          pend.push_back(n);
        end else begin
          mdl_ovf = 1'b1;
        end
      end
      while (pend.size() > 0 && pend[0].resp_e < e) void'(pend.pop_front());
      exp_en   = (pend.size() > 0) && (pend[0].resp_e == e);
      exp_data = exp_en ? pend[0].data : '0;
      exp_oh   = exp_en ? pend[0].oh   : '0;
      occ = 0;
      foreach (pend[i]) if (pend[i].pop_e > e) occ++;
      exp_ready = (occ < FIFO_DEPTH);
    end
  end

  // ---------------- compare + response log ----------------
  typedef struct {
    logic [BIT_WIDTH-1:0] data;
    logic [RADIX-1:0]     oh;
    int                   e;
  } rsp_t;
  rsp_t got[$];

  always @(negedge clk) begin
    check("en_M2C_IN", en_M2C_IN, exp_en);
    check("Data_M2C_IN", Data_M2C_IN, exp_data);
    check("AccessComplete", AccessComplete_M2C_IN, exp_oh);
    check("ready_C2M", ready_C2M, exp_ready);
    check("overflow_err", overflow_err, mdl_ovf);
    if (en_M2C_IN) got.push_back('{data: Data_M2C_IN, oh: AccessComplete_M2C_IN, e: cyc});
  end

  // ---------------- stimulus ----------------
  int req_e;

  task automatic send(input logic [ADDR_WIDTH-1:0] a, input logic [BIT_WIDTH-1:0] d);
    @(negedge clk);
    en_C2M_OUT   = 1'b1;
    Addr_C2M_OUT = a;
    Data_C2M_OUT = d;
    req_e        = cyc + 1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    en_C2M_OUT   = 1'b0;
    Addr_C2M_OUT = '0;
    Data_C2M_OUT = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready", ready_C2M, 1'b1);
    check("reset_en", en_M2C_IN, 1'b0);
    rst_l = 1'b1;
    idle(2);
    check("post_reset_ovf", overflow_err, 1'b0);

    // Single read of a never-written word.
    got.delete();
    send(16'h0005, 32'h0);
    begin
      int k;
      k = req_e;
      idle(10);
      check("single_count", got.size(), 1);
      if (got.size() >= 1) begin
        check("single_data", got[0].data, 32'h0);
        check("single_oh", got[0].oh, 2'b01);
        check("single_latency", got[0].e - k, 3);
      end
    end

    // Write from core 0 then read from core 1, same word.
    got.delete();
    send(16'h8003, 32'hDEADBEEF);
    send(16'h4003, 32'h0);
    idle(15);
    check("wr_rd_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("wr_rsp_oh", got[0].oh, 2'b01);
      check("wr_rsp_data", got[0].data, 32'hDEADBEEF);
      check("rd_rsp_oh", got[1].oh, 2'b10);
      check("rd_rsp_data", got[1].data, 32'hDEADBEEF);
      check("wr_rd_spacing", got[1].e - got[0].e, LATENCY + 2);
    end

    // Five back-to-back: all fit because the first pops immediately.
    got.delete();
    send(16'h8001, 32'h11111111);
    send(16'hC002, 32'h22222222);
    send(16'h0001, 32'h0);
    send(16'h4002, 32'h0);
    send(16'h0003, 32'h0);
    idle(30);
    check("five_count", got.size(), 5);
    check("five_ovf", overflow_err, 1'b0);
    if (got.size() >= 5) begin
      check("five_rd1_data", got[2].data, 32'h11111111);
      check("five_rd2_oh", got[3].oh, 2'b10);
      check("five_rd3_data", got[4].data, 32'hDEADBEEF);
    end

    // Seven back-to-back writes: the seventh finds the queue full.
    got.delete();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 5) check("full_ready_low", ready_C2M, 1'b0);
      en_C2M_OUT   = 1'b1;
      Addr_C2M_OUT = 16'h8004 + 16'(i);
      Data_C2M_OUT = 32'hA0000000 + 32'(i);
    end
    idle(40);
    check("seven_count", got.size(), 6);
    check("seven_ovf", overflow_err, 1'b1);
    if (got.size() >= 6) begin
      check("seven_first", got[0].data, 32'hA0000000);
      check("seven_last", got[5].data, 32'hA0000005);
    end

    // Reset while the first request is in its access wait.
    got.delete();
    send(16'h8003, 32'h12345678);
    send(16'h4003, 32'h0);
    @(negedge clk);
    en_C2M_OUT = 1'b0;
    #2 rst_l = 1'b0;
    #1 check("rst_en_low", en_M2C_IN, 1'b0);
    check("rst_ready", ready_C2M, 1'b1);
    check("rst_ovf_clear", overflow_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    idle(12);
    check("rst_no_rsp", got.size(), 0);
    send(16'h0003, 32'h0);
    idle(10);
    check("rst_read_count", got.size(), 1);
    if (got.size() >= 1) check("rst_mem_cleared", got[0].data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
